// File: rtl/countdown_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | countdown_timer: loadable down-counter with start handshake and a     |
// | one-cycle done pulse. Optional macro: COUNTDOWN_AUTO_RELOAD_EN.       |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module countdown_timer #(
   parameter int width     = 8,
   parameter int decrement = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [width-1:0] load_value,
   input  logic             enable,
   input  logic             abort,
   output logic [width-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [width-1:0] c_dec  = width'(decrement);
   localparam logic [width-1:0] c_zero = '0;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [width-1:0] r_count;
   logic [width-1:0] w_count_nxt;
   logic             w_handshake;

   assign start_ready = (r_state == c_idle);
   assign w_handshake = start_valid & start_ready;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   // The period copy is only ever consumed by the reload path.
   logic [width-1:0] r_period;
   logic [width-1:0] w_period_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_period <= c_zero;
      end else begin
         r_period <= w_period_nxt;
      end
   end

   always_comb begin
      w_period_nxt = r_period;
      if (w_handshake) begin
         w_period_nxt = load_value;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         c_idle: begin
            if (w_handshake) begin
               w_count_nxt = load_value;
               w_state_nxt = (load_value == c_zero) ? c_done : c_run;
            end
         end
         c_run: begin
            // abort outranks both a normal tick and an expiring tick
            if (abort) begin
               w_count_nxt = c_zero;
               w_state_nxt = c_idle;
            end else if (enable) begin
               if (r_count > c_dec) begin
                  w_count_nxt = r_count - c_dec;
               end else begin
                  w_count_nxt = c_zero;
                  w_state_nxt = c_done;
               end
            end
         end
         c_done: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // A zero period would otherwise spin in DONE; park it in IDLE.
            if (abort || (r_period == c_zero)) begin
               w_count_nxt = c_zero;
               w_state_nxt = c_idle;
            end else begin
               w_count_nxt = r_period;
               w_state_nxt = c_run;
            end
`else
            w_count_nxt = c_zero;
            w_state_nxt = c_idle;
`endif
         end
         default: begin
            w_count_nxt = c_zero;
            w_state_nxt = c_idle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
         r_count <= c_zero;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign count = r_count;
   assign busy  = (r_state == c_run);
   assign done  = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_countdown_timer: scoreboard bench for countdown_timer.              |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_countdown_timer;

   typedef struct packed {
      logic [7:0] count;
      logic       busy;
      logic       done;
      logic       ready;
   } exp_t;

   logic       clk;
   logic       reset;

   logic       a_start, a_ready, a_en, a_abort, a_busy, a_done;
   logic [7:0] a_load, a_count;
   logic       b_start, b_ready, b_en, b_abort, b_busy, b_done;
   logic [7:0] b_load, b_count;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];
   exp_t e, obs;

   countdown_timer #(.width(8), .decrement(1)) dut_a (
      .clk(clk), .reset(reset),
      .start_valid(a_start), .start_ready(a_ready), .load_value(a_load),
      .enable(a_en), .abort(a_abort),
      .count(a_count), .busy(a_busy), .done(a_done)
   );

   countdown_timer #(.width(8), .decrement(3)) dut_b (
      .clk(clk), .reset(reset),
      .start_valid(b_start), .start_ready(b_ready), .load_value(b_load),
      .enable(b_en), .abort(b_abort),
      .count(b_count), .busy(b_busy), .done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input int c, input bit b, input bit d, input bit r);
      exp_t x;
      x.count = 8'(c);
      x.busy  = b;
      x.done  = d;
      x.ready = r;
      return x;
   endfunction

   function automatic string fmt(input exp_t x);
      return $sformatf("cnt=%0d busy=%b done=%b rdy=%b", x.count, x.busy, x.done, x.ready);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      obs = {a_count, a_busy, a_done, a_ready};
      e   = mk(0, 0, 0, 1);
      n_total++;
      if (obs !== e) $display("FAIL reset_async_a: got %s want %s", fmt(obs), fmt(e));
      else n_pass++;
      obs = {b_count, b_busy, b_done, b_ready};
      n_total++;
      if (obs !== e) $display("FAIL reset_async_b: got %s want %s", fmt(obs), fmt(e));
      else n_pass++;
      @(negedge clk);
      obs = {a_count, a_busy, a_done, a_ready};
      n_total++;
      if (obs !== e) $display("FAIL reset_held: got %s want %s", fmt(obs), fmt(e));
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (a_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", a_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 7; k++) begin
         a_start = (k <= 5);
         a_load  = (k == 0) ? 8'd5 : 8'd99;
         a_en    = 1'b1;
         a_abort = 1'b0;
         if (k <= 4)      sb.push_back(mk(5 - k, 1, 0, 0));
         else if (k == 5) sb.push_back(mk(0, 0, 1, 0));
         else             sb.push_back(mk(0, 0, 0, 1));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL basic[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      a_start = 1'b0;
   endtask

   task automatic test_decrement3();
      for (int k = 0; k < 5; k++) begin
         b_start = (k == 0);
         b_load  = 8'd7;
         b_en    = 1'b1;
         b_abort = 1'b0;
         case (k)
            0:       sb.push_back(mk(7, 1, 0, 0));
            1:       sb.push_back(mk(4, 1, 0, 0));
            2:       sb.push_back(mk(1, 1, 0, 0));
            3:       sb.push_back(mk(0, 0, 1, 0));
            default: sb.push_back(mk(0, 0, 0, 1));
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {b_count, b_busy, b_done, b_ready};
         n_total++;
         if (obs !== e) $display("FAIL dec3[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      b_en = 1'b0;
   endtask

   task automatic test_zero_load();
      for (int k = 0; k < 3; k++) begin
         a_start = (k == 0);
         a_load  = 8'd0;
         a_en    = 1'b1;
         a_abort = 1'b0;
         if (k == 0) sb.push_back(mk(0, 0, 1, 0));
         else        sb.push_back(mk(0, 0, 0, 1));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL zero_load[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
   endtask

   task automatic test_enable_abort();
      for (int k = 0; k < 18; k++) begin
         a_start = (k == 0);
         a_load  = 8'd10;
         a_en    = (k >= 15) ? 1'b1 : ((k % 2) == 1);
         a_abort = (k == 15);
         if (k == 0)       sb.push_back(mk(10, 1, 0, 0));
         else if (k <= 14) sb.push_back(mk(10 - (k + 1) / 2, 1, 0, 0));
         else              sb.push_back(mk(0, 0, 0, 1));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL enable_abort[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      a_abort = 1'b0;
   endtask

   task automatic test_abort_idle_done();
      for (int k = 0; k < 5; k++) begin
         a_start = (k == 0);
         a_load  = 8'd2;
         a_en    = 1'b1;
         a_abort = (k == 0) || (k == 3);
         case (k)
            0:       sb.push_back(mk(2, 1, 0, 0));
            1:       sb.push_back(mk(1, 1, 0, 0));
            2:       sb.push_back(mk(0, 0, 1, 0));
            default: sb.push_back(mk(0, 0, 0, 1));
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL abort_idle_done[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      a_abort = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 7; k++) begin
         a_start = (k <= 4);
         a_load  = (k < 4) ? 8'd2 : 8'd1;
         a_en    = 1'b1;
         a_abort = 1'b0;
         case (k)
            0:       sb.push_back(mk(2, 1, 0, 0));
            1:       sb.push_back(mk(1, 1, 0, 0));
            2:       sb.push_back(mk(0, 0, 1, 0));
            3:       sb.push_back(mk(0, 0, 0, 1));
            4:       sb.push_back(mk(1, 1, 0, 0));
            5:       sb.push_back(mk(0, 0, 1, 0));
            default: sb.push_back(mk(0, 0, 0, 1));
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL back_to_back[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      a_start = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 5; k++) begin
         a_start = (k == 0);
         a_load  = 8'd8;
         a_en    = 1'b1;
         a_abort = 1'b0;
         sb.push_back(mk(8 - k, 1, 0, 0));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL async_reset_run[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (a_count !== 8'd0 || a_busy !== 1'b0 || a_done !== 1'b0)
         $display("FAIL async_reset_immediate: got cnt=%0d busy=%b done=%b want cnt=0 busy=0 done=0",
                  a_count, a_busy, a_done);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         sb.push_back(mk(0, 0, 0, 1));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL async_reset_after[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
   endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      for (int k = 0; k < 14; k++) begin
         a_start = (k == 0);
         a_load  = 8'd3;
         a_en    = 1'b1;
         a_abort = (k == 12);
         if (k >= 12)            sb.push_back(mk(0, 0, 0, 1));
         else if ((k % 4) == 3)  sb.push_back(mk(0, 0, 1, 0));
         else                    sb.push_back(mk(3 - (k % 4), 1, 0, 0));
         @(negedge clk);
         e   = sb.pop_front();
         obs = {a_count, a_busy, a_done, a_ready};
         n_total++;
         if (obs !== e) $display("FAIL auto_reload[%0d]: got %s want %s", k, fmt(obs), fmt(e));
         else n_pass++;
      end
      a_abort = 1'b0;
   endtask
`endif

   initial begin
      a_start = 1'b0; a_load = 8'd0; a_en = 1'b0; a_abort = 1'b0;
      b_start = 1'b0; b_load = 8'd0; b_en = 1'b0; b_abort = 1'b0;
      test_reset();
      test_zero_load();
      test_enable_abort();
      test_abort_idle_done();
      test_async_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`else
      test_basic();
      test_decrement3();
      test_back_to_back();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
